// File: rtl/object_scanner_pkg.sv
// Shared descriptor layout, object type codes and scanner state encoding
// for the object_scanner block and its comparator.
package object_scanner_pkg;

  localparam int DATALEN  = 39;
  localparam int TYPE_LSB = 0;
  localparam int TYPE_LEN = 3;
  localparam int X_LSB    = 3;
  localparam int X_LEN    = 10;
  localparam int Y_LSB    = 13;
  localparam int Y_LEN    = 10;
  localparam int W_LSB    = 23;
  localparam int W_LEN    = 8;
  localparam int H_LSB    = 31;
  localparam int H_LEN    = 8;

  localparam int DEF_XW = 10;
  localparam int DEF_YW = 10;

  typedef enum logic [2:0] {
    OBJ_NULL   = 3'd0,
    OBJ_GROUND = 3'd1,
    OBJ_DINO   = 3'd2,
    OBJ_CACTUS = 3'd3,
    OBJ_BIRD   = 3'd4
  } obj_type_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } scan_state_e;

  function automatic logic [2:0] desc_type(input logic [DATALEN-1:0] d);
    return d[TYPE_LSB +: TYPE_LEN];
  endfunction

endpackage

// File: rtl/object_scanner_if.sv
// Pixel query / result handshake bundle between the display path (master)
// and object_scanner (slave).
interface object_scanner_if #(
  parameter int NOBJ = 4,
  parameter int XW   = 10,
  parameter int YW   = 10
);
  localparam int IW = $clog2(NOBJ);

  logic          px_valid;
  logic          px_ready;
  logic [XW-1:0] px_x;
  logic [YW-1:0] px_y;
  logic          res_valid;
  logic          res_ready;
  logic          res_hit;
  logic [2:0]    res_type;
  logic [IW-1:0] res_index;

  modport master (
    output px_valid, px_x, px_y, res_ready,
    input  px_ready, res_valid, res_hit, res_type, res_index
  );

  modport slave (
    input  px_valid, px_x, px_y, res_ready,
    output px_ready, res_valid, res_hit, res_type, res_index
  );
endinterface

// File: rtl/object_scanner_rect_contains.sv
// rect_contains comparator: does the point (x, y) fall inside the descriptor's
// half-open rectangle? Bounds are widened by one bit so x+width never wraps.
module object_scanner_rect_contains
  import object_scanner_pkg::*;
#(
  parameter int XW = DEF_XW,
  parameter int YW = DEF_YW
) (
  input  logic [DATALEN-1:0] desc_i,
  input  logic [XW-1:0]      x_i,
  input  logic [YW-1:0]      y_i,
  output logic               hit_o
);
  logic [XW:0] x_lo_s, x_hi_s, px_s;
  logic [YW:0] y_lo_s, y_hi_s, py_s;

  assign x_lo_s = (XW+1)'(desc_i[X_LSB +: X_LEN]);
  assign x_hi_s = x_lo_s + (XW+1)'(desc_i[W_LSB +: W_LEN]);
  assign y_lo_s = (YW+1)'(desc_i[Y_LSB +: Y_LEN]);
  assign y_hi_s = y_lo_s + (YW+1)'(desc_i[H_LSB +: H_LEN]);
  assign px_s   = {1'b0, x_i};
  assign py_s   = {1'b0, y_i};

  // Zero width/height makes lo == hi, so the strict upper bound rejects it
  assign hit_o = (desc_type(desc_i) != OBJ_NULL) &&
                 (px_s >= x_lo_s) && (px_s < x_hi_s) &&
                 (py_s >= y_lo_s) && (py_s < y_hi_s);
endmodule

// File: rtl/object_scanner.sv
// Per-pixel object lookup over a frame-consistent descriptor snapshot.
// Optional dino/obstacle overlap flag: define OBJECT_SCANNER_COLLISION_EN.
module object_scanner
  import object_scanner_pkg::*;
#(
  parameter int NOBJ = 4,
  parameter int XW   = DEF_XW,
  parameter int YW   = DEF_YW
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    frame_start_i,
  input  logic [NOBJ*DATALEN-1:0] objs_i,
  object_scanner_if.slave         px_if,
  output logic                    collide_o
);
  localparam int IW = $clog2(NOBJ);

  scan_state_e        state_q, state_d;
  logic               pending_q, pending_d;
  logic [IW-1:0]      idx_q, idx_d;
  logic [XW-1:0]      qx_q, qx_d;
  logic [YW-1:0]      qy_q, qy_d;
  logic               hit_q, hit_d;
  logic [2:0]         type_q, type_d;
  logic [IW-1:0]      index_q, index_d;
  logic               px_ready_q, px_ready_d;
  logic               res_valid_q, res_valid_d;
  logic               latch_s;
  logic [DATALEN-1:0] shadow_q [NOBJ];
  logic [DATALEN-1:0] cur_desc_s;
  logic               cand_hit_s;

  assign cur_desc_s = shadow_q[idx_q];

  object_scanner_rect_contains #(.XW(XW), .YW(YW)) u_rect (
    .desc_i (cur_desc_s),
    .x_i    (qx_q),
    .y_i    (qy_q),
    .hit_o  (cand_hit_s)
  );

  // Next-state, snapshot request and result capture
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q | frame_start_i;
    idx_d     = idx_q;
    qx_d      = qx_q;
    qy_d      = qy_q;
    hit_d     = hit_q;
    type_d    = type_q;
    index_d   = index_q;
    latch_s   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pending_q) begin
          latch_s   = 1'b1;
          pending_d = frame_start_i;
        end else if (px_if.px_valid && px_ready_q) begin
          qx_d    = px_if.px_x;
          qy_d    = px_if.px_y;
          idx_d   = {IW{1'b0}};
          state_d = ST_SCAN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SCAN: begin
        if (cand_hit_s) begin
          hit_d   = 1'b1;
          type_d  = desc_type(cur_desc_s);
          index_d = idx_q;
          state_d = ST_DONE;
        end else if (idx_q == IW'(NOBJ - 1)) begin
          hit_d   = 1'b0;
          type_d  = OBJ_NULL;
          index_d = {IW{1'b0}};
          state_d = ST_DONE;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      ST_DONE: begin
        if (px_if.res_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    px_ready_d  = (state_d == ST_IDLE) && !pending_d;
    res_valid_d = (state_d == ST_DONE);
  end

  // Control and result registers
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= ST_IDLE;
      pending_q   <= 1'b0;
      idx_q       <= {IW{1'b0}};
      qx_q        <= {XW{1'b0}};
      qy_q        <= {YW{1'b0}};
      hit_q       <= 1'b0;
      type_q      <= 3'd0;
      index_q     <= {IW{1'b0}};
      px_ready_q  <= 1'b1;
      res_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      idx_q       <= idx_d;
      qx_q        <= qx_d;
      qy_q        <= qy_d;
      hit_q       <= hit_d;
      type_q      <= type_d;
      index_q     <= index_d;
      px_ready_q  <= px_ready_d;
      res_valid_q <= res_valid_d;
    end
  end

  // Snapshot copy, only ever taken while idle so a scan never sees a mix
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int i = 0; i < NOBJ; i++) shadow_q[i] <= {DATALEN{1'b0}};
    end else if (latch_s) begin
      for (int i = 0; i < NOBJ; i++) shadow_q[i] <= objs_i[i*DATALEN +: DATALEN];
    end
  end

  assign px_if.px_ready  = px_ready_q;
  assign px_if.res_valid = res_valid_q;
  assign px_if.res_hit   = hit_q;
  assign px_if.res_type  = type_q;
  assign px_if.res_index = index_q;

`ifdef OBJECT_SCANNER_COLLISION_EN
  logic latch_q;
  logic overlap_s;
  logic collide_q;

  // Strict overlap: touching edges leave lo == hi on one side and fail '<'
  function automatic logic rects_overlap(input logic [DATALEN-1:0] a,
                                         input logic [DATALEN-1:0] b);
    logic [X_LEN:0] ax0, ax1, bx0, bx1;
    logic [Y_LEN:0] ay0, ay1, by0, by1;
    logic           kinds;
    ax0   = (X_LEN+1)'(a[X_LSB +: X_LEN]);
    ax1   = ax0 + (X_LEN+1)'(a[W_LSB +: W_LEN]);
    bx0   = (X_LEN+1)'(b[X_LSB +: X_LEN]);
    bx1   = bx0 + (X_LEN+1)'(b[W_LSB +: W_LEN]);
    ay0   = (Y_LEN+1)'(a[Y_LSB +: Y_LEN]);
    ay1   = ay0 + (Y_LEN+1)'(a[H_LSB +: H_LEN]);
    by0   = (Y_LEN+1)'(b[Y_LSB +: Y_LEN]);
    by1   = by0 + (Y_LEN+1)'(b[H_LSB +: H_LEN]);
    kinds = (desc_type(a) == OBJ_DINO) &&
            ((desc_type(b) == OBJ_CACTUS) || (desc_type(b) == OBJ_BIRD));
    return kinds && (ax0 < bx1) && (bx0 < ax1) && (ay0 < by1) && (by0 < ay1);
  endfunction

  // OR of slot-0 overlap against every other slot of the fresh snapshot
  always_comb begin
    overlap_s = 1'b0;
    for (int i = 1; i < NOBJ; i++) begin
      if (rects_overlap(shadow_q[0], shadow_q[i])) begin
        overlap_s = 1'b1;
      end else begin
        overlap_s = overlap_s;
      end
    end
  end

  // Collision flag refreshes one edge after each latch and holds otherwise
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      latch_q   <= 1'b0;
      collide_q <= 1'b0;
    end else begin
      latch_q <= latch_s;
      if (latch_q) collide_q <= overlap_s;
    end
  end

  assign collide_o = collide_q;
`else
  assign collide_o = 1'b0;
`endif

endmodule

// File: tb/tb_object_scanner.sv
// Self-checking bench for object_scanner: spec-level model plus directed queries.
module tb_object_scanner;
  import object_scanner_pkg::*;

  localparam int NOBJ = 4;
  localparam int XW   = 10;
  localparam int YW   = 10;
  localparam int IW   = 2;
`ifdef OBJECT_SCANNER_COLLISION_EN
  localparam bit COLL_EN = 1'b1;
`else
  localparam bit COLL_EN = 1'b0;
`endif

  logic                    clk = 1'b0;
  logic                    reset = 1'b1;
  logic                    frame_start = 1'b0;
  logic [NOBJ*DATALEN-1:0] objs = '0;
  logic                    collide;

  object_scanner_if #(.NOBJ(NOBJ), .XW(XW), .YW(YW)) bus ();

  object_scanner #(.NOBJ(NOBJ), .XW(XW), .YW(YW)) dut (
    .clk_i         (clk),
    .reset_i       (reset),
    .frame_start_i (frame_start),
    .objs_i        (objs),
    .px_if         (bus.slave),
    .collide_o     (collide)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic logic [DATALEN-1:0] mk(input int t, input int x, input int y,
                                            input int w, input int h);
    return {h[7:0], w[7:0], y[9:0], x[9:0], t[2:0]};
  endfunction

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic          hit;
    logic [2:0]    typ;
    logic [IW-1:0] idx;
    int            lat;
  } res_t;

  function automatic res_t model_scan(input logic [NOBJ*DATALEN-1:0] snap, input int px, input int py);
    res_t r;
    logic [DATALEN-1:0] d;
    int t, x, y, w, h;
    r.hit = 1'b0; r.typ = 3'd0; r.idx = '0; r.lat = NOBJ;
    for (int i = 0; i < NOBJ; i++) begin
      d = snap[i*DATALEN +: DATALEN];
      t = int'(d[2:0]);  x = int'(d[12:3]); y = int'(d[22:13]);
      w = int'(d[30:23]); h = int'(d[38:31]);
      if (!r.hit && t != 0 && px >= x && px < x + w && py >= y && py < y + h) begin
        r.hit = 1'b1; r.typ = d[2:0]; r.idx = IW'(i); r.lat = i + 1;
      end
    end
    return r;
  endfunction

  function automatic logic model_overlap(input logic [NOBJ*DATALEN-1:0] snap);
    logic [DATALEN-1:0] a, b;
    logic o;
    int ax, ay, aw, ah, bx, by, bw, bh;
    o = 1'b0;
    a = snap[DATALEN-1:0];
    ax = int'(a[12:3]); ay = int'(a[22:13]); aw = int'(a[30:23]); ah = int'(a[38:31]);
    for (int i = 1; i < NOBJ; i++) begin
      b = snap[i*DATALEN +: DATALEN];
      bx = int'(b[12:3]); by = int'(b[22:13]); bw = int'(b[30:23]); bh = int'(b[38:31]);
      if (a[2:0] == 3'd2 && (b[2:0] == 3'd3 || b[2:0] == 3'd4) &&
          ax < bx + bw && bx < ax + aw && ay < by + bh && by < ay + ah) o = 1'b1;
    end
    return o;
  endfunction

  int                    m_mode = 0;   // 0 idle, 1 busy, 2 result pending
  logic                  m_pending = 1'b0;
  logic [NOBJ*DATALEN-1:0] m_snap = '0;
  int                    m_cnt = 0;
  res_t                  m_res;
  logic                  m_collide = 1'b0;
  logic                  m_latch_prev = 1'b0;
  logic                  m_latch_now, m_accept;

  assign m_latch_now = (m_mode == 0) && m_pending;
  assign m_accept    = (m_mode == 0) && !m_pending && bus.px_valid;

  always @(posedge clk) begin
    if (reset) begin
      m_mode <= 0; m_pending <= 1'b0; m_snap <= '0; m_cnt <= 0;
      m_collide <= 1'b0; m_latch_prev <= 1'b0;
    end else begin
      m_pending    <= (m_pending && !m_latch_now) || frame_start;
      m_latch_prev <= m_latch_now;
      if (m_latch_now) m_snap <= objs;
      if (m_latch_prev) m_collide <= COLL_EN && model_overlap(m_snap);
      if (m_accept) begin
        m_res  <= model_scan(m_snap, int'(bus.px_x), int'(bus.px_y));
        m_cnt  <= model_scan(m_snap, int'(bus.px_x), int'(bus.px_y)).lat;
        m_mode <= 1;
      end else if (m_mode == 1) begin
        if (m_cnt == 1) m_mode <= 2;
        else m_cnt <= m_cnt - 1;
      end else if (m_mode == 2 && bus.res_ready) begin
        m_mode <= 0;
      end
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      chk("model px_ready", bus.px_ready, (m_mode == 0) && !m_pending);
      chk("model res_valid", bus.res_valid, m_mode == 2);
      chk("model collide", collide, m_collide);
      if (m_mode == 2) begin
        chk("model res_hit", bus.res_hit, m_res.hit);
        chk("model res_type", bus.res_type, m_res.typ);
        chk("model res_index", bus.res_index, m_res.idx);
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic latch_objs(input string nm, input logic [NOBJ*DATALEN-1:0] o, input bit exp_coll);
    objs = o;
    frame_start = 1'b1;
    @(posedge clk); #1 frame_start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk({nm, " collide"}, collide, COLL_EN && exp_coll);
  endtask

  task automatic do_query(input string nm, input int x, input int y, input bit eh,
                          input int et, input int ei, input int elat,
                          input int hold, input bit fs_pulse);
    int w;
    int lat;
    bus.px_x = x[XW-1:0];
    bus.px_y = y[YW-1:0];
    bus.px_valid = 1'b1;
    bus.res_ready = (hold == 0);
    w = 0;
    @(negedge clk);
    while (!bus.px_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk({nm, " accept"}, bus.px_ready, 1);
    @(posedge clk); #1 bus.px_valid = 1'b0;
    if (fs_pulse) frame_start = 1'b1;
    lat = 0;
    do begin
      @(posedge clk); #1 frame_start = 1'b0;
      lat++;
    end while (!bus.res_valid && lat < 40);
    chk({nm, " latency"}, lat, elat);
    chk({nm, " hit"}, bus.res_hit, eh);
    chk({nm, " type"}, bus.res_type, et);
    chk({nm, " index"}, bus.res_index, ei);
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1;
      chk({nm, " hold valid"}, bus.res_valid, 1);
      chk({nm, " hold px_ready"}, bus.px_ready, 0);
      chk({nm, " hold type"}, bus.res_type, et);
      chk({nm, " hold index"}, bus.res_index, ei);
    end
    bus.res_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  logic [NOBJ*DATALEN-1:0] s1, s2, s3;

  initial begin
    bus.px_valid = 1'b0; bus.px_x = '0; bus.px_y = '0; bus.res_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 chk_en = 1'b1;
    reset = 1'b0;
    chk("reset px_ready", bus.px_ready, 1);
    chk("reset res_valid", bus.res_valid, 0);
    chk("reset res_hit", bus.res_hit, 0);
    chk("reset res_type", bus.res_type, 0);
    chk("reset res_index", bus.res_index, 0);
    chk("reset collide", collide, 0);

    do_query("empty", 5, 5, 1'b0, 0, 0, 4, 0, 1'b0);

    s1 = {mk(0, 0, 0, 0, 0), mk(4, 195, 145, 20, 10), mk(3, 200, 140, 10, 30), mk(2, 40, 100, 20, 20)};
    latch_objs("s1", s1, 1'b0);
    do_query("dino tl", 40, 100, 1'b1, 2, 0, 1, 0, 1'b0);
    do_query("dino right", 60, 100, 1'b0, 0, 0, 4, 0, 1'b0);
    do_query("dino br", 59, 119, 1'b1, 2, 0, 1, 0, 1'b0);
    do_query("cactus prio", 200, 150, 1'b1, 3, 1, 2, 0, 1'b0);
    do_query("bird", 196, 146, 1'b1, 4, 2, 3, 0, 1'b0);
    do_query("bird edge", 214, 154, 1'b1, 4, 2, 3, 0, 1'b0);
    do_query("bird out", 215, 150, 1'b0, 0, 0, 4, 0, 1'b0);

    // snapshot request during a scan: old slot1 answers, latch follows
    s2 = s1;
    s2[DATALEN +: DATALEN] = mk(0, 200, 140, 10, 30);
    objs = s2;
    do_query("fs old", 205, 160, 1'b1, 3, 1, 2, 0, 1'b1);
    chk("fs latch cycle px_ready", bus.px_ready, 0);
    @(posedge clk); #1;
    chk("fs after latch px_ready", bus.px_ready, 1);
    do_query("fs new", 205, 160, 1'b0, 0, 0, 4, 0, 1'b0);
    do_query("fs new bird", 200, 150, 1'b1, 4, 2, 3, 0, 1'b0);

    do_query("hold", 40, 100, 1'b1, 2, 0, 1, 3, 1'b0);

    // reset in the middle of a scan
    bus.px_x = 10'd5; bus.px_y = 10'd5; bus.px_valid = 1'b1; bus.res_ready = 1'b1;
    @(negedge clk);
    chk("rst accept", bus.px_ready, 1);
    @(posedge clk); #1 bus.px_valid = 1'b0;
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    chk("rst mid px_ready", bus.px_ready, 1);
    chk("rst mid res_valid", bus.res_valid, 0);
    chk("rst mid res_hit", bus.res_hit, 0);
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      chk("rst no result", bus.res_valid, 0);
    end

    // zero-size rectangles, GROUND hits, and no wrap at the top of the range
    s3 = {mk(4, 1000, 1000, 255, 255), mk(1, 0, 0, 255, 255), mk(3, 10, 10, 5, 0), mk(2, 10, 10, 0, 5)};
    latch_objs("s3", s3, 1'b0);
    do_query("zero size", 10, 10, 1'b1, 1, 2, 3, 0, 1'b0);
    do_query("no wrap", 1023, 1023, 1'b1, 4, 3, 4, 0, 1'b0);

    // collision flag
    latch_objs("coll cactus", {mk(0, 0, 0, 0, 0), mk(0, 0, 0, 0, 0), mk(3, 55, 110, 10, 30), mk(2, 40, 100, 20, 20)}, 1'b1);
    do_query("coll prio", 56, 111, 1'b1, 2, 0, 1, 0, 1'b0);
    latch_objs("coll touch x", {mk(0, 0, 0, 0, 0), mk(0, 0, 0, 0, 0), mk(3, 60, 110, 10, 30), mk(2, 40, 100, 20, 20)}, 1'b0);
    latch_objs("coll ground", {mk(0, 0, 0, 0, 0), mk(0, 0, 0, 0, 0), mk(1, 45, 105, 10, 10), mk(2, 40, 100, 20, 20)}, 1'b0);
    latch_objs("coll bird3", {mk(4, 50, 115, 30, 30), mk(0, 0, 0, 0, 0), mk(0, 0, 0, 0, 0), mk(2, 40, 100, 20, 20)}, 1'b1);
    latch_objs("coll touch y", {mk(4, 50, 120, 30, 30), mk(0, 0, 0, 0, 0), mk(0, 0, 0, 0, 0), mk(2, 40, 100, 20, 20)}, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    bad++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/object_scanner.md
# object_scanner

Reads the packed object descriptors produced by the game-object generators (ground, dinosaur, obstacles) and answers per-pixel "which object covers this coordinate" queries for the display path. A frame-start pulse latches a consistent snapshot of all descriptors. Each pixel query walks the snapshot in priority order (index 0 highest) and returns the first covering object through a valid/ready result port. It is the consumer end of the descriptor bus.

## Interface
- NOBJ, 4, number of descriptor slots scanned (2..16)
- XW, 10, x-coordinate width
- YW, 10, y-coordinate width
- clk  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high
- frame_start  in  1  pulse: request snapshot of objs
- objs  in  NOBJ*DATALEN  packed descriptors, slot i at [i*DATALEN +: DATALEN]
- px_valid  in  1  query valid
- px_ready  out  1  query accepted when px_valid && px_ready
- px_x  in  XW  query x
- px_y  in  YW  query y
- res_valid  out  1  result valid
- res_ready  in  1  result consumed when res_valid && res_ready
- res_hit  out  1  1 = some object covers the pixel
- res_type  out  3  type of covering object, NULL on miss
- res_index  out  clog2(NOBJ)  slot of covering object, 0 on miss
- collide  out  1  dinosaur/obstacle overlap flag (see Configuration)

## Operation
- Descriptor layout, DATALEN=39: type [2:0], x [12:3], y [22:13], width [30:23], height [38:31]. Types: NULL=0, GROUND=1, DINO=2, CACTUS=3, BIRD=4.
- Snapshot: NOBJ shadow registers; reset clears all to zero (type NULL). frame_start sets pending; the copy objs -> shadow happens on an edge where state is IDLE and pending is set, then pending clears. Queries never see a partial update.
- FSM IDLE -> SCAN -> DONE -> IDLE.
- IDLE: px_ready = 1 unless pending. Accepting a query registers px_x/px_y, sets idx=0, goes to SCAN.
- SCAN: each cycle tests shadow[idx]. Hit means all of: type != NULL; x <= px_x < x+width; y <= px_y < y+height.
- Sums are computed at XW+1 and YW+1 bits, with no wrap. Width or height 0 never hits.
- On a hit: register hit=1, type, index; go to DONE.
- On a miss at idx = NOBJ-1: register hit=0, type=NULL, index=0; go to DONE.
- Otherwise increment idx.
- DONE: res_valid=1 and outputs stay stable until res_ready; on the handshake edge return to IDLE.
- frame_start in SCAN/DONE: the current query completes on the old snapshot; the latch happens on the first IDLE edge, during which px_ready=0.
- Synchronous reset in any state: state -> IDLE, pending=0, and any in-flight query is discarded.
- Reset values: px_ready=1, res_valid=0, res_hit=0, res_type=0, res_index=0, collide=0.

## Timing
- Query accepted at edge T. A hit at slot k gives res_valid high after edge T+1+k. A miss gives res_valid after edge T+NOBJ.
- Minimum query period is k+3 cycles when res_ready is held high.
- The snapshot latch costs one IDLE cycle.
- collide updates on the edge after each snapshot latch and holds between latches.

## Configuration
- OBJECT_SCANNER_COLLISION_EN defined: on the cycle after each latch, collide = OR over slots i>=1 with type CACTUS or BIRD of strict rectangle overlap with slot 0 (type DINO). Edges that only touch do not count. GROUND never collides.
- Undefined: collide is tied 0 and no overlap logic is built.

## Structure
- Shared package (next to the existing data-field macros): DATALEN, field start/len constants, type codes, default XW/YW.
- Sub-module rect_contains: point-in-rectangle comparator (descriptor, x, y -> hit), one instance used by SCAN.
- Overlap logic stays inline under the macro.

## Test plan
- Reset, no frame_start, query (5,5) at T -> res_valid after T+4 (NOBJ=4), res_hit=0, res_type=0, res_index=0.
- Latch slot0 DINO x=40 y=100 w=20 h=20; query (40,100) -> hit, type 2, index 0, res_valid after T+1. Query (60,100) -> miss. Query (59,119) -> hit.
- Slot1 CACTUS x=200 y=140 w=10 h=30 and slot2 BIRD x=195 y=145 w=20 h=10; query (200,150) -> type 3, index 1, after T+2.
- Assert frame_start during SCAN with slot1 changed -> that result uses the old slot1. px_ready is 0 for one IDLE cycle. The next query sees the new slot1.
- Hold res_ready=0 for 3 cycles in DONE -> res_valid and result fields stable, px_ready=0. Assert reset mid-SCAN -> next cycle IDLE, res_valid=0.
- With the macro, slot0 DINO (40,100,20,20) and slot1 CACTUS (55,110,10,30) -> collide=1 one cycle after latch. CACTUS at x=60 -> 0. GROUND overlap -> 0. Without the macro, collide is always 0.
